ddio_capture_fsm: RTL

Next-state and datapath-control stage for the DDIO capture path. Consumes the registered current state `state_reg` and produces `state_next` for the downstream state register (clocked from the PLL `clk`, no reset of its own). Sequences one fixed-length capture burst per `start` request. Packs each DDIO high/low sample pair into one word and drives a write port into the capture buffer.

---
 rtl/ddio_pkg.sv | 13 +
 rtl/ddio_capture_fsm.sv | 114 +++++++++++
 2 files changed

// File: rtl/ddio_pkg.sv
// Shared definitions for the DDIO capture path: state width and one-hot encodings.
package ddio_pkg;

  localparam int unsigned NBR_STATES = 2;
  localparam int unsigned STATE_W    = NBR_STATES + 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'b001,
    ST_CAPTURE = 3'b010,
    ST_DONE    = 3'b100
  } state_e;

endpackage

// File: rtl/ddio_capture_fsm.sv
// Next-state and datapath control for the DDIO capture path. The state
// register itself lives outside this block: state_next goes out, state_reg
// comes back. One fixed-length burst of packed h/l words is written to the
// capture buffer per start request.
module ddio_capture_fsm
  import ddio_pkg::*;
#(
  parameter int unsigned NBR_STATES = ddio_pkg::NBR_STATES,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HOLDOFF    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NBR_STATES:0]   state_reg,
  input  logic [DATA_W/2-1:0]   ddio_h,
  input  logic [DATA_W/2-1:0]   ddio_l,
  input  logic                  ddio_valid,
  output logic [NBR_STATES:0]   state_next,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  start_missed
);

  // cnt carries one extra bit so a burst of 2^ADDR_W words reaches its
  // final compare without wrapping.
  localparam int unsigned     HCNT_W    = $clog2(HOLDOFF) + 1;
  localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W+1)'(BURST_LEN - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLDOFF - 1);

  logic [NBR_STATES:0] state_d;
  logic [ADDR_W:0]     cnt_d, cnt_q;
  logic [HCNT_W-1:0]   hcnt_d, hcnt_q;
  logic                wr_en_d, wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]   wr_data_d, wr_data_q;
  logic                done_d, done_q;
  logic                start_missed_d, start_missed_q;

  // Next-state decode plus next values for counters and write-port registers.
  always_comb begin
    state_d        = ST_IDLE;
    cnt_d          = cnt_q;
    hcnt_d         = hcnt_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    done_d         = 1'b0;
    start_missed_d = start_missed_q;
    case (state_reg)
      ST_IDLE: begin
        cnt_d   = '0;
        hcnt_d  = '0;
        state_d = start ? ST_CAPTURE : ST_IDLE;
      end
      ST_CAPTURE: begin
        state_d = ST_CAPTURE;
        if (start) start_missed_d = 1'b1;
        if (ddio_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = {ddio_h, ddio_l};
          cnt_d     = cnt_q + (ADDR_W+1)'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start) start_missed_d = 1'b1;
        hcnt_d  = hcnt_q + HCNT_W'(1);
        state_d = (hcnt_q == HCNT_LAST) ? ST_IDLE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) state_d = ST_IDLE;
  end

  // Counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      hcnt_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      done_q         <= 1'b0;
      start_missed_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      hcnt_q         <= hcnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      done_q         <= done_d;
      start_missed_q <= start_missed_d;
    end
  end

  assign state_next   = state_d;
  assign busy         = (state_reg != ST_IDLE);
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign done         = done_q;
  assign start_missed = start_missed_q;

endmodule
